link_pixel_pipeline: RTL and testbench
======================================

# link_pixel_pipeline

Pixel pipeline between the VGA timing generator and the display DAC.
- Per pixel, it computes the background and Link sprite ROM addresses from the draw coordinates and captures the returned colour indices.
- It drives those indices into the background and sprite palette lookups, then composites the returned RGB with sprite transparency and blanking.
- It delays hsync, vsync and blank so that they stay aligned with the pixel colour.
- It owns the walk-animation frame toggle for the sprite.

## Interface
Parameters:
- SPR_SIZE, 32: sprite edge length in pixels (power of two).
- BG_SHIFT, 2: background downscale; background ROM is 160x120 for a 640x480 display.
- ANIM_FRAMES, 8: vsyncs per walk-frame toggle.
- TRANSPARENT_IDX, 4'h0: sprite index treated as transparent.

Ports:
- Clk  in  1  pixel clock, 25 MHz. One clock; reset is synchronous and active-low.
- Reset_n  in  1  synchronous, active-low reset.
- DrawX, DrawY  in  10 each  current pixel coordinates from the VGA controller.
- hs_in, vs_in, blank_in  in  1 each  VGA timing signals; hs/vs are active-low; blank_in=0 means blanked.
- LinkX, LinkY  in  10 each  top-left corner of the sprite. Sampled once per frame.
- dir  in  2  facing direction: 0 up, 1 down, 2 left, 3 right.
- moving  in  1  high while Link walks.
- bg_rom_addr  out  15  background ROM address. ROM has 1-cycle read latency.
- bg_rom_q  in  4  background index.
- spr_rom_addr  out  13  address formed as {dir, frame, row[4:0], col[4:0]}. ROM has 1-cycle read latency.
- spr_rom_q  in  4  sprite index. 3-bit ROMs are zero-extended by the caller.
- bg_pal_index, spr_pal_index  out  4 each  to the combinational palettes.
- bg_rgb, spr_rgb  in  12 each  {r,g,b} returned by the palettes in the same cycle.
- red, green, blue  out  4 each  final colour.
- hs_out, vs_out, blank_out  out  1 each  delayed timing signals.

## Operation
- **S0 (address):**
  - bg_rom_addr = (DrawY>>BG_SHIFT)*160 + (DrawX>>BG_SHIFT), computed as (y<<7)+(y<<5)+x in 15 bits; there is no overflow for in-range coordinates.
  - Sprite hit when LinkX ≤ DrawX < LinkX+SPR_SIZE and LinkY ≤ DrawY < LinkY+SPR_SIZE. Compares are 11 bits wide so that LinkX+SPR_SIZE > 1023 does not wrap.
  - row = DrawY−LinkY and col = DrawX−LinkX, each truncated to 5 bits.
  - On a miss, spr_rom_addr is 0 and the hit flag is cleared.
- **S1 (index):** register bg_rom_q and spr_rom_q and the hit flag. If hit=0, force spr_pal_index to TRANSPARENT_IDX. bg_pal_index and spr_pal_index are these registered values.
- **S2 (colour):** the output register takes:
  - 0 when blank_d=0;
  - else spr_rgb when hit and spr index ≠ TRANSPARENT_IDX;
  - else bg_rgb.
- **Frame latch:** LinkX, LinkY and dir are captured into shadow registers on the falling edge of vs_in. This prevents tearing mid-frame.
- **Animation counter:**
  - A 3-bit counter increments on each vs_in falling edge while moving=1. When it reaches ANIM_FRAMES−1 it wraps to 0 and toggles `frame`.
  - When moving=0, the counter and frame clear to 0 at the next vs falling edge.
  - A dir change while moving keeps `frame` unchanged.
- **Reset (Reset_n=0 at a rising Clk edge):**
  - red, green and blue = 0, hs_out = vs_out = 1, blank_out = 0.
  - All pipeline stages are cleared; counter = 0, frame = 0, shadow position = 0, dir = 0.
  - Reset mid-line simply restarts; the VGA controller re-synchronises.

## Timing
- Latency from DrawX/DrawY/hs_in/vs_in/blank_in to red/green/blue/hs_out/vs_out/blank_out is exactly 3 Clk.
- The timing signals pass through a 3-deep shift register. At every cycle, the colour is the colour for the coordinate presented 3 cycles earlier.
- vs edge detection uses one registered copy of vs_in. The shadow registers update one cycle after the edge is seen.
- The palettes are combinational; no registered path exists between the index and RGB within S1→S2.
- Throughput: one pixel per Clk, with no stalls.

## Structure
- Shared package `zelda_pkg`:
  - typedef rgb12_t;
  - enum dir_t {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};
  - constants SCREEN_W=640, SCREEN_H=480, BG_W=160.
- One sub-module, `sprite_anim_ctrl`, holds the vs edge detect, shadow latch, anim counter and frame.
- The address and compositing datapath stays in the top module.

## Test plan
- Reset held for 4 cycles, then released with blank_in=1 -> red/green/blue=0, hs_out=vs_out=1, blank_out=0 until 3 cycles after release.
- DrawX=8, DrawY=4, no sprite hit -> bg_rom_addr=(1*160)+2=162 in the same cycle. With the ROM model returning 4'h5 and bg_rgb=12'h5A2, the output is {5,A,2} exactly 3 cycles later.
- LinkX=100, LinkY=50, dir=3, frame=0; DrawX=101, DrawY=52 -> spr_rom_addr={2'b11,1'b0,5'd2,5'd1}=13'h1841. With spr_rom_q=3 and spr_rgb=12'hD94, the output is D94. With spr_rom_q=0, the output is the background colour.
- blank_in=0 while inside the sprite -> output 000 three cycles later, and blank_out=0.
- With moving=1 over 16 vs falling edges, frame toggles after the 8th and 16th edges. Dropping moving to 0 clears frame at the next vs edge.
- LinkX changed from 100 to 300 mid-frame -> the hit region stays at 100 until after the next vs falling edge.

Source files
------------

// File: rtl/zelda_pkg.sv
// Shared types and screen constants for the Zelda video path.
package zelda_pkg;

    typedef logic [11:0] rgb12_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BG_W     = 160;

    // Row base of the downscaled background: y*160 built as y*128 + y*32.
    function automatic logic [14:0] bgRowBase(input logic [9:0] y);
        return (15'(y) << 7) + (15'(y) << 5);
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Per-frame sprite state: vsync falling-edge detect, position/direction
// shadow latch and the walk-animation counter with its frame toggle.
module sprite_anim_ctrl
    import zelda_pkg::*;
#(
    parameter int ANIM_FRAMES = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       vs_i,
    input  logic       moving_i,
    input  logic [9:0] linkX_i,
    input  logic [9:0] linkY_i,
    input  dir_t       dir_i,
    output logic [9:0] linkX_o,
    output logic [9:0] linkY_o,
    output dir_t       dir_o,
    output logic       frame_o
);

    localparam logic [2:0] LAST_CNT = 3'(ANIM_FRAMES - 1);

    logic       vsPrev_q;
    logic       vsFall;
    logic [9:0] linkX_q, linkX_d;
    logic [9:0] linkY_q, linkY_d;
    dir_t       dir_q, dir_d;
    logic [2:0] animCnt_q, animCnt_d;
    logic       frame_q, frame_d;

    // Everything here changes only at the start of vertical sync, so a
    // frame is always drawn with one consistent position and pose.
    always_comb begin
        vsFall    = vsPrev_q & ~vs_i;
        linkX_d   = linkX_q;
        linkY_d   = linkY_q;
        dir_d     = dir_q;
        animCnt_d = animCnt_q;
        frame_d   = frame_q;
        if (vsFall) begin
            linkX_d = linkX_i;
            linkY_d = linkY_i;
            dir_d   = dir_i;
            if (!moving_i) begin
                animCnt_d = '0;
                frame_d   = 1'b0;
            end else if (animCnt_q == LAST_CNT) begin
                animCnt_d = '0;
                frame_d   = ~frame_q;
            end else begin
                animCnt_d = animCnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vsPrev_q  <= 1'b1;
            linkX_q   <= '0;
            linkY_q   <= '0;
            dir_q     <= DIR_UP;
            animCnt_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            vsPrev_q  <= vs_i;
            linkX_q   <= linkX_d;
            linkY_q   <= linkY_d;
            dir_q     <= dir_d;
            animCnt_q <= animCnt_d;
            frame_q   <= frame_d;
        end
    end

    assign linkX_o = linkX_q;
    assign linkY_o = linkY_q;
    assign dir_o   = dir_q;
    assign frame_o = frame_q;

endmodule

// File: rtl/link_pixel_pipeline.sv
// Three-stage pixel pipeline: ROM addressing, palette index capture and
// sprite-over-background compositing, with timing signals delayed to match.
module link_pixel_pipeline
    import zelda_pkg::*;
#(
    parameter int         SPR_SIZE        = 32,
    parameter int         BG_SHIFT        = 2,
    parameter int         ANIM_FRAMES     = 8,
    parameter logic [3:0] TRANSPARENT_IDX = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        blank_in,
    input  logic [9:0]  LinkX,
    input  logic [9:0]  LinkY,
    input  logic [1:0]  dir,
    input  logic        moving,
    output logic [14:0] bg_rom_addr,
    input  logic [3:0]  bg_rom_q,
    output logic [12:0] spr_rom_addr,
    input  logic [3:0]  spr_rom_q,
    output logic [3:0]  bg_pal_index,
    output logic [3:0]  spr_pal_index,
    input  logic [11:0] bg_rgb,
    input  logic [11:0] spr_rgb,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_out
);

    logic [9:0]  shadowX, shadowY;
    dir_t        shadowDir;
    logic        frame;
    logic [9:0]  bgX, bgY;
    logic [10:0] x11, y11, lx11, ly11;
    logic        sprHit;
    logic [4:0]  sprRow, sprCol;

    logic        hit0_q, hit1_q;
    logic [3:0]  bgIdx_q;
    logic [3:0]  sprIdx_q, sprIdx_d;
    rgb12_t      rgb_q, rgb_d;
    logic [2:0]  hsDly_q, vsDly_q, blankDly_q;

    sprite_anim_ctrl #(
        .ANIM_FRAMES(ANIM_FRAMES)
    ) uAnim (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .vs_i     (vs_in),
        .moving_i (moving),
        .linkX_i  (LinkX),
        .linkY_i  (LinkY),
        .dir_i    (dir_t'(dir)),
        .linkX_o  (shadowX),
        .linkY_o  (shadowY),
        .dir_o    (shadowDir),
        .frame_o  (frame)
    );

    assign bgX         = DrawX >> BG_SHIFT;
    assign bgY         = DrawY >> BG_SHIFT;
    assign bg_rom_addr = bgRowBase(bgY) + 15'(bgX);

    // 11-bit compares keep a sprite hanging off the right/bottom edge from wrapping.
    assign x11    = {1'b0, DrawX};
    assign y11    = {1'b0, DrawY};
    assign lx11   = {1'b0, shadowX};
    assign ly11   = {1'b0, shadowY};
    assign sprHit = (x11 >= lx11) && (x11 < lx11 + 11'(SPR_SIZE)) &&
                    (y11 >= ly11) && (y11 < ly11 + 11'(SPR_SIZE));
    assign sprRow = 5'(DrawY - shadowY);
    assign sprCol = 5'(DrawX - shadowX);

    assign spr_rom_addr = sprHit ? {shadowDir, frame, sprRow, sprCol} : '0;

    always_comb begin
        sprIdx_d = hit0_q ? spr_rom_q : TRANSPARENT_IDX;
        rgb_d    = bg_rgb;
        if (!blankDly_q[1]) begin
            rgb_d = '0;
        end else if (hit1_q && (sprIdx_q != TRANSPARENT_IDX)) begin
            rgb_d = spr_rgb;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hit0_q     <= 1'b0;
            hit1_q     <= 1'b0;
            bgIdx_q    <= '0;
            sprIdx_q   <= '0;
            rgb_q      <= '0;
            hsDly_q    <= '1;
            vsDly_q    <= '1;
            blankDly_q <= '0;
        end else begin
            hit0_q     <= sprHit;
            hit1_q     <= hit0_q;
            bgIdx_q    <= bg_rom_q;
            sprIdx_q   <= sprIdx_d;
            rgb_q      <= rgb_d;
            hsDly_q    <= {hsDly_q[1:0], hs_in};
            vsDly_q    <= {vsDly_q[1:0], vs_in};
            blankDly_q <= {blankDly_q[1:0], blank_in};
        end
    end

    assign bg_pal_index  = bgIdx_q;
    assign spr_pal_index = sprIdx_q;
    assign red           = rgb_q[11:8];
    assign green         = rgb_q[7:4];
    assign blue          = rgb_q[3:0];
    assign hs_out        = hsDly_q[2];
    assign vs_out        = vsDly_q[2];
    assign blank_out     = blankDly_q[2];

endmodule

// File: tb/tb_link_pixel_pipeline.sv
// Directed bench for link_pixel_pipeline: vector table for the pixel path,
// hand sequences for frame latching and walk animation.
module tb_link_pixel_pipeline;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [3:0]  bgQ;
        logic [3:0]  sprQ;
        logic [14:0] expBg;
        logic [12:0] expSpr;
        logic [11:0] expRgb;
    } vec_t;

    localparam int NUM_VEC = 11;

    logic        clk = 1'b0;
    logic        resetN;
    logic [9:0]  drawX, drawY, linkX, linkY;
    logic        hsIn, vsIn, blankIn, moving;
    logic [1:0]  dirIn;
    logic [14:0] bgRomAddr;
    logic [12:0] sprRomAddr;
    logic [3:0]  bgRomQ, sprRomQ, curBgQ, curSprQ;
    logic [3:0]  bgPalIdx, sprPalIdx;
    logic [11:0] bgRgb, sprRgb;
    logic [3:0]  red, green, blue;
    logic        hsOut, vsOut, blankOut;

    int checks = 0;
    int fails  = 0;
    vec_t vecs [NUM_VEC];

    link_pixel_pipeline dut (
        .Clk          (clk),
        .Reset_n      (resetN),
        .DrawX        (drawX),
        .DrawY        (drawY),
        .hs_in        (hsIn),
        .vs_in        (vsIn),
        .blank_in     (blankIn),
        .LinkX        (linkX),
        .LinkY        (linkY),
        .dir          (dirIn),
        .moving       (moving),
        .bg_rom_addr  (bgRomAddr),
        .bg_rom_q     (bgRomQ),
        .spr_rom_addr (sprRomAddr),
        .spr_rom_q    (sprRomQ),
        .bg_pal_index (bgPalIdx),
        .spr_pal_index(sprPalIdx),
        .bg_rgb       (bgRgb),
        .spr_rgb      (sprRgb),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hs_out       (hsOut),
        .vs_out       (vsOut),
        .blank_out    (blankOut)
    );

    always #20 clk = ~clk;

    // ROMs return the value programmed with the pixel one clock later.
    always @(posedge clk) begin
        bgRomQ  <= curBgQ;
        sprRomQ <= curSprQ;
    end

    assign bgRgb  = {bgPalIdx, ~bgPalIdx, bgPalIdx ^ 4'h7};
    assign sprRgb = {sprPalIdx + 4'hA, sprPalIdx * 4'd3, sprPalIdx + 4'h1};

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        drawX   = v.x;
        drawY   = v.y;
        hsIn    = v.hs;
        vsIn    = v.vs;
        blankIn = v.blank;
        curBgQ  = v.bgQ;
        curSprQ = v.sprQ;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        checkVal($sformatf("rgb[%0d]", idx), {red, green, blue}, v.expRgb);
        checkVal($sformatf("hs_out[%0d]", idx), hsOut, v.hs);
        checkVal($sformatf("vs_out[%0d]", idx), vsOut, v.vs);
        checkVal($sformatf("blank_out[%0d]", idx), blankOut, v.blank);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkVal({tag, " rgb"}, {red, green, blue}, 12'h000);
        checkVal({tag, " hs_out"}, hsOut, 1'b1);
        checkVal({tag, " vs_out"}, vsOut, 1'b1);
        checkVal({tag, " blank_out"}, blankOut, 1'b0);
    endtask

    task automatic vsPulse();
        @(negedge clk);
        vsIn = 1'b0;
        @(negedge clk);
        vsIn = 1'b1;
        @(negedge clk);
    endtask

    task automatic checkSprAt(input string name, input logic [9:0] x, input logic [9:0] y,
                              input logic [12:0] exp);
        drawX = x;
        drawY = y;
        #1;
        checkVal(name, sprRomAddr, exp);
    endtask

    initial begin
        vecs[0]  = '{10'd8,   10'd4,   1'b1, 1'b1, 1'b1, 4'h5, 4'h3, 15'd162,   13'h0000, 12'h5A2};
        vecs[1]  = '{10'd101, 10'd52,  1'b0, 1'b1, 1'b1, 4'h5, 4'h3, 15'd2105,  13'h1841, 12'hD94};
        vecs[2]  = '{10'd101, 10'd52,  1'b1, 1'b0, 1'b1, 4'h5, 4'h0, 15'd2105,  13'h1841, 12'h5A2};
        vecs[3]  = '{10'd101, 10'd52,  1'b1, 1'b1, 1'b0, 4'h5, 4'h3, 15'd2105,  13'h1841, 12'h000};
        vecs[4]  = '{10'd131, 10'd81,  1'b1, 1'b1, 1'b1, 4'h9, 4'h7, 15'd3232,  13'h1BFF, 12'h158};
        vecs[5]  = '{10'd132, 10'd60,  1'b1, 1'b1, 1'b1, 4'h9, 4'h7, 15'd2433,  13'h0000, 12'h96E};
        vecs[6]  = '{10'd100, 10'd82,  1'b0, 1'b1, 1'b1, 4'hC, 4'h2, 15'd3225,  13'h0000, 12'hC3B};
        vecs[7]  = '{10'd100, 10'd50,  1'b1, 1'b1, 1'b1, 4'h1, 4'hF, 15'd1945,  13'h1800, 12'h9D0};
        vecs[8]  = '{10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 4'h2, 4'h4, 15'd19199, 13'h0000, 12'h2D5};
        vecs[9]  = '{10'd99,  10'd50,  1'b1, 1'b1, 1'b1, 4'h3, 4'h5, 15'd1944,  13'h0000, 12'h3C4};
        vecs[10] = '{10'd0,   10'd0,   1'b1, 1'b1, 1'b0, 4'h7, 4'h0, 15'd0,     13'h0000, 12'h000};

        resetN  = 1'b0;
        drawX   = '0;
        drawY   = '0;
        hsIn    = 1'b0;
        vsIn    = 1'b1;
        blankIn = 1'b1;
        linkX   = '0;
        linkY   = '0;
        dirIn   = 2'd0;
        moving  = 1'b0;
        curBgQ  = '0;
        curSprQ = '0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkIdleOutputs($sformatf("reset%0d", i));
        end
        resetN = 1'b1;
        hsIn   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkIdleOutputs($sformatf("release%0d", i));
        end
        @(negedge clk);
        checkVal("blank_out after 3 cycles", blankOut, 1'b1);

        linkX = 10'd100;
        linkY = 10'd50;
        dirIn = 2'd3;
        vsPulse();

        // Stream the table back to back; each pixel's colour is due 3 clocks later.
        for (int i = 0; i < NUM_VEC + 3; i++) begin
            @(negedge clk);
            if (i >= 3) checkOutput(i - 3, vecs[i - 3]);
            if (i < NUM_VEC) begin
                applyStimulus(vecs[i]);
                #1;
                checkVal($sformatf("bg_rom_addr[%0d]", i), bgRomAddr, vecs[i].expBg);
                checkVal($sformatf("spr_rom_addr[%0d]", i), sprRomAddr, vecs[i].expSpr);
            end else begin
                applyStimulus('{10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 15'd0, 13'h0, 12'h0});
            end
        end

        // Position written mid-frame must not take effect until vsync.
        @(negedge clk);
        linkX = 10'd300;
        @(negedge clk);
        checkSprAt("midframe old hit", 10'd101, 10'd52, 13'h1841);
        vsPulse();
        checkSprAt("after vs old miss", 10'd101, 10'd52, 13'h0000);
        checkSprAt("after vs new hit", 10'd301, 10'd52, 13'h1841);

        linkX = 10'd1000;
        vsPulse();
        checkSprAt("right edge hit", 10'd1023, 10'd52, 13'h1857);
        checkSprAt("no wrap miss", 10'd5, 10'd52, 13'h0000);

        linkX  = 10'd100;
        moving = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            vsPulse();
            checkSprAt($sformatf("walk A edge %0d", k), 10'd101, 10'd52,
                       {2'd3, (k >= 8 && k < 16) ? 1'b1 : 1'b0, 5'd2, 5'd1});
        end
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) dirIn = 2'd0;
            vsPulse();
            checkSprAt($sformatf("walk B edge %0d", k), 10'd101, 10'd52,
                       {(k >= 4) ? 2'd0 : 2'd3, (k == 8) ? 1'b1 : 1'b0, 5'd2, 5'd1});
        end
        moving = 1'b0;
        vsPulse();
        checkSprAt("stop clears frame", 10'd101, 10'd52, 13'h0041);
        moving = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            vsPulse();
            checkSprAt($sformatf("walk D edge %0d", k), 10'd101, 10'd52,
                       {2'd0, (k == 8) ? 1'b1 : 1'b0, 5'd2, 5'd1});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
